// File: rtl/spawn_cell_picker.sv
// Picks a random 7x4 playfield cell that avoids the most recently delivered cells,
// then presents its index and pixel position under a valid/ready handshake.
module spawn_cell_picker #(
   parameter int HIST_DEPTH = 4,
   parameter int MAX_RETRY  = 8,
   parameter int RETRY_GAP  = 6,
   parameter int CELL_W     = 12,
   parameter int CELL_H     = 12,
   parameter int X_OFF      = 6,
   parameter int Y_OFF      = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] rnd,
   input  logic       req,
   input  logic       clear_hist,
   output logic       cell_valid,
   input  logic       cell_ready,
   output logic [4:0] cell_idx,
   output logic [6:0] cell_x,
   output logic [5:0] cell_y,
   output logic       busy
);

   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam int GW = $clog2(RETRY_GAP + 1);

   typedef enum logic [2:0] {IDLE, SAMPLE, CHECK, WAIT, PROBE, HOLD} state_t;

   state_t                  state;
   logic [4:0]              cand;
   logic [RW-1:0]           retry;
   logic [GW-1:0]           gap;
   logic [4:0]              hist_idx [HIST_DEPTH];
   logic [HIST_DEPTH-1:0]   hist_vld;

   logic [4:0] rnd_norm;
   logic [4:0] probe_next;
   logic [4:0] check_val;
   logic       hit;
   logic [1:0] row;
   logic [4:0] col;
   logic [6:0] pix_x;
   logic [5:0] pix_y;

   assign busy = (state != IDLE);

   // The value under test is the candidate in CHECK and the next probe position in PROBE,
   // so a free probe can be delivered in the same cycle it is reached.
   always_comb begin
      rnd_norm   = (rnd >= 5'd28) ? rnd - 5'd28 : rnd;
      probe_next = (cand == 5'd27) ? 5'd0 : cand + 5'd1;
      check_val  = (state == PROBE) ? probe_next : cand;
      hit = 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
         if (hist_vld[i] && hist_idx[i] == check_val) hit = 1'b1;
      end
      if (check_val >= 5'd21)      row = 2'd3;
      else if (check_val >= 5'd14) row = 2'd2;
      else if (check_val >= 5'd7)  row = 2'd1;
      else                         row = 2'd0;
      col   = check_val - {3'b000, row} * 5'd7;
      pix_x = 7'(X_OFF) + 7'(col) * 7'(CELL_W);
      pix_y = 6'(Y_OFF) + 6'(row) * 6'(CELL_H);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cand       <= '0;
         retry      <= '0;
         gap        <= '0;
         hist_vld   <= '0;
         cell_valid <= 1'b0;
         cell_idx   <= '0;
         cell_x     <= '0;
         cell_y     <= '0;
         for (int i = 0; i < HIST_DEPTH; i++) hist_idx[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  retry <= '0;
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               cand  <= rnd_norm;
               state <= CHECK;
            end
            CHECK: begin
               if (!hit) begin
                  cell_idx   <= check_val;
                  cell_x     <= pix_x;
                  cell_y     <= pix_y;
                  cell_valid <= 1'b1;
                  state      <= HOLD;
               end else if (retry == RW'(MAX_RETRY - 1)) begin
                  state <= PROBE;
               end else begin
                  retry <= retry + 1'b1;
                  gap   <= '0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (gap == GW'(RETRY_GAP - 1)) begin
                  gap   <= '0;
                  state <= SAMPLE;
               end else begin
                  gap <= gap + 1'b1;
               end
            end
            PROBE: begin
               cand <= probe_next;
               if (!hit) begin
                  cell_idx   <= check_val;
                  cell_x     <= pix_x;
                  cell_y     <= pix_y;
                  cell_valid <= 1'b1;
                  state      <= HOLD;
               end
            end
            HOLD: begin
               if (cell_ready) begin
                  cell_valid  <= 1'b0;
                  state       <= IDLE;
                  hist_idx[0] <= cell_idx;
                  hist_vld[0] <= 1'b1;
                  for (int i = 1; i < HIST_DEPTH; i++) begin
                     hist_idx[i] <= hist_idx[i-1];
                     hist_vld[i] <= hist_vld[i-1];
                  end
               end
            end
            default: state <= IDLE;
         endcase
         // Placed after the case so a clear in the transfer cycle overrides the push.
         if (clear_hist) hist_vld <= '0;
      end
   end

endmodule

// File: tb/tb_spawn_cell_picker.sv
// Scoreboard bench for spawn_cell_picker: each request pushes the expected cell and
// latency, and a monitor pops and compares on every rising cell_valid.
module tb_spawn_cell_picker;

   logic       clock;
   logic       reset;
   logic [4:0] rnd;
   logic       req;
   logic       clear_hist;
   logic       cell_valid;
   logic       cell_ready;
   logic [4:0] cell_idx;
   logic [6:0] cell_x;
   logic [5:0] cell_y;
   logic       busy;

   typedef struct {
      int idx;
      int req_cycle;
      int lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic prev_valid = 1'b0;

   spawn_cell_picker dut (
      .clock      (clock),
      .reset      (reset),
      .rnd        (rnd),
      .req        (req),
      .clear_hist (clear_hist),
      .cell_valid (cell_valid),
      .cell_ready (cell_ready),
      .cell_idx   (cell_idx),
      .cell_x     (cell_x),
      .cell_y     (cell_y),
      .busy       (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Compares each delivered cell against the oldest outstanding expectation.
   always @(negedge clock) begin
      if (reset && cell_valid && !prev_valid) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_valid", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("idx", int'(cell_idx), mon_e.idx);
            checkOutput("x", int'(cell_x), 6 + (mon_e.idx % 7) * 12);
            checkOutput("y", int'(cell_y), 8 + (mon_e.idx / 7) * 12);
            checkOutput("latency", cyc - mon_e.req_cycle, mon_e.lat);
         end
      end
      prev_valid = reset && cell_valid;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic [4:0] r, input bit push, input int exp_idx, input int exp_lat);
      exp_t e;
      rnd = r;
      req = 1'b1;
      if (push) begin
         e.idx = exp_idx;
         e.req_cycle = cyc;
         e.lat = exp_lat;
         sb.push_back(e);
      end
      @(negedge clock);
      req = 1'b0;
   endtask

   task automatic waitValid(input int budget);
      int n = 0;
      while (!cell_valid && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (!cell_valid) checkOutput("timeout_valid", 0, 1);
   endtask

   task automatic checkReset();
      checkOutput("rst_valid", int'(cell_valid), 0);
      checkOutput("rst_idx", int'(cell_idx), 0);
      checkOutput("rst_x", int'(cell_x), 0);
      checkOutput("rst_y", int'(cell_y), 0);
      checkOutput("rst_busy", int'(busy), 0);
   endtask

   task automatic pick(input logic [4:0] r, input int exp_idx, input int exp_lat);
      applyStimulus(r, 1'b1, exp_idx, exp_lat);
      cell_ready = 1'b1;
      waitValid(exp_lat + 20);
      @(negedge clock);
      cell_ready = 1'b0;
      checkOutput("idle_after", int'(busy), 0);
      checkOutput("valid_drop", int'(cell_valid), 0);
   endtask

   initial begin
      rnd = 5'd0;
      req = 1'b0;
      clear_hist = 1'b0;
      cell_ready = 1'b0;
      reset = 1'b1;
      #1 reset = 1'b0;
      repeat (3) @(negedge clock);
      checkReset();
      reset = 1'b1;
      @(negedge clock);

      // Seed history with 5, then abort a retrying pick with reset during WAIT
      pick(5'd5, 5, 3);
      applyStimulus(5'd5, 1'b0, 0, 0);
      repeat (4) @(negedge clock);
      checkOutput("busy_wait", int'(busy), 1);
      reset = 1'b0;
      #1;
      checkReset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      pick(5'd9, 9, 3);
      // 5 is accepted at once only if reset emptied the history
      pick(5'd5, 5, 3);

      // One rejected sample, then 12 on the retry
      applyStimulus(5'd5, 1'b1, 12, 11);
      cell_ready = 1'b1;
      repeat (3) @(negedge clock);
      rnd = 5'd12;
      waitValid(30);
      @(negedge clock);
      cell_ready = 1'b0;
      checkOutput("idle_retry", int'(busy), 0);

      clear_hist = 1'b1;
      @(negedge clock);
      clear_hist = 1'b0;
      pick(5'd2, 2, 3);
      pick(5'd1, 1, 3);
      pick(5'd0, 0, 3);
      pick(5'd27, 27, 3);

      // All samples hit 27, so linear probing wraps 27->0->1->2->3
      applyStimulus(5'd27, 1'b1, 3, 2 + 8 * 7 + 1 + 4);
      cell_ready = 1'b1;
      waitValid(150);
      @(negedge clock);
      cell_ready = 1'b0;

      // rnd=30 normalises to 2; hold with ready low and a second ignored req
      applyStimulus(5'd30, 1'b1, 2, 3);
      waitValid(20);
      for (int i = 0; i < 10; i++) begin
         checkOutput("hold_valid", int'(cell_valid), 1);
         checkOutput("hold_idx", int'(cell_idx), 2);
         checkOutput("hold_x", int'(cell_x), 30);
         checkOutput("hold_y", int'(cell_y), 8);
         req = (i == 2);
         @(negedge clock);
      end
      req = 1'b0;
      cell_ready = 1'b1;
      @(negedge clock);
      cell_ready = 1'b0;
      checkOutput("idle_hold", int'(busy), 0);
      for (int i = 0; i < 8; i++) begin
         checkOutput("no_requeue", int'(busy), 0);
         @(negedge clock);
      end

      // Clear in the transfer cycle of 7 wins over the push
      applyStimulus(5'd7, 1'b1, 7, 3);
      waitValid(20);
      clear_hist = 1'b1;
      cell_ready = 1'b1;
      @(negedge clock);
      clear_hist = 1'b0;
      cell_ready = 1'b0;
      checkOutput("idle_clear", int'(busy), 0);
      pick(5'd2, 2, 3);
      pick(5'd7, 7, 3);

      repeat (5) @(negedge clock);
      checkOutput("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spawn_cell_picker.md
Name: spawn_cell_picker

Overview:
- Consumes the 5-bit random value (0..27) from the LFSR and turns it into a non-repeating spawn cell on the 96x64 OLED playfield.
- The playfield is a 7-column x 4-row grid (28 cells).
- On each request the block picks a cell that is not among the last HIST_DEPTH cells delivered, converts it to pixel coordinates, and holds it under a valid/ready handshake until the game logic accepts it.

Parameters:
HIST_DEPTH, 4, number of recently delivered cells excluded from picks (1..8)
MAX_RETRY, 8, rejected random samples before falling back to linear probing
RETRY_GAP, 6, cycles between random samples (the LFSR output refreshes every 6 clocks)
CELL_W, 12, cell width in pixels
CELL_H, 12, cell height in pixels
X_OFF, 6, x pixel of column 0
Y_OFF, 8, y pixel of row 0

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low; low clears all state
rnd  input  5  random value from LFSR, nominally 0..27
req  input  1  single-cycle pick request
clear_hist  input  1  empties the history (level, sampled each cycle)
cell_valid  output  1  picked cell is presented
cell_ready  input  1  consumer accepts cell when high with cell_valid
cell_idx  output  5  cell index 0..27 (row*7 + col)
cell_x  output  7  X_OFF + (cell_idx % 7) * CELL_W
cell_y  output  6  Y_OFF + (cell_idx / 7) * CELL_H
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset low, asynchronous): state IDLE; cell_valid=0, cell_idx=0, cell_x=0, cell_y=0, busy=0; history valid bits cleared; retry counter and gap counter cleared. Reset asserted mid-pick aborts the pick with no partial output.
- Input normalisation: rnd values 28..31 are reduced by 28 (becoming 0..3) before use.
- IDLE:
  - req=1 moves to SAMPLE and zeroes the retry counter.
  - req is ignored in every other state; no queuing.
- SAMPLE:
  - Registers the normalised rnd into the candidate.
  - Moves to CHECK.
- CHECK:
  - The candidate is compared combinationally against all valid history entries.
  - Free: cell_idx/x/y are registered from the candidate, cell_valid=1, move to HOLD. Best case is req at cycle 0 and cell_valid high at cycle 3.
  - Hit with retry < MAX_RETRY-1: increment retry, move to WAIT.
  - Hit with retry = MAX_RETRY-1: move to PROBE.
- WAIT:
  - Counts RETRY_GAP-1 cycles, then moves to SAMPLE.
- PROBE:
  - Each cycle sets candidate = (candidate+1) mod 28 (27 wraps to 0).
  - If the new candidate is free, register the outputs, set cell_valid, and move to HOLD.
  - Because HIST_DEPTH < 28, a free cell is reached within HIST_DEPTH+1 probes.
- HOLD:
  - Outputs are stable while cell_valid=1 and cell_ready=0.
  - On cell_valid & cell_ready: push cell_idx into the history shift register (newest at entry 0, oldest dropped once HIST_DEPTH are valid), cell_valid=0, move to IDLE.
  - cell_ready while cell_valid=0 has no effect.
- clear_hist:
  - Clears all history valid bits in that cycle; it does not change state or outputs.
  - If it coincides with a HOLD transfer, clear wins and the history is empty afterwards.
  - If it is asserted during CHECK or PROBE, the comparison in that cycle still uses the pre-clear history.
- Arithmetic: the x/y mapping is computed from the registered index using constant multiplies. Column is idx % 7 and row is idx / 7, both computed with comparisons; no divider.

Test Plan:
- Reset low mid-WAIT, then release -> all outputs 0, busy=0, empty history. Next req with rnd=9 -> cell_valid on the 3rd cycle with cell_idx=9, cell_x=30, cell_y=20.
- Empty history, req with rnd=27, cell_ready held 1 -> cell_idx=27, cell_x=78, cell_y=44. Transfer in the HOLD cycle, back to IDLE next cycle.
- History {5}, rnd=5 at first sample and 12 after RETRY_GAP -> one retry, cell_idx=12. Delivery 3+RETRY_GAP+2 cycles after req.
- History {27,0,1,2}, rnd held at 27 for all samples -> after MAX_RETRY rejects, PROBE wraps 27->0->1->2->3. Result cell_idx=3.
- rnd=30 with empty history -> cell_idx=2. cell_ready held 0 for 10 cycles keeps outputs stable; second req during HOLD is ignored.
- clear_hist asserted in the same cycle as the transfer of idx=7 -> history empty. Next pick with rnd=7 is accepted immediately.
